// File: rtl/ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ctrl_pkg: shared widths and state encoding for the control group  |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
package ctrl_pkg;

  localparam int ADDRW      = 8;
  localparam int OPCODEW    = 2;
  localparam int INSTRW     = 2 * ADDRW + OPCODEW;
  localparam int OP_SHA_BIT = 0;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    SHIFT     = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/req_deserializer_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | req_deserializer_if: CPU serial link, queue handshake, err flags  |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
interface req_deserializer_if
  import ctrl_pkg::*;
#(
  parameter int ADDRW   = ctrl_pkg::ADDRW,
  parameter int OPCODEW = ctrl_pkg::OPCODEW
);

  logic               spi_sclk;
  logic               spi_cs_n;
  logic               spi_mosi;
  logic               ready_in_aes;
  logic               ready_in_sha;
  logic               err_clr;
  logic [OPCODEW-1:0] opcode;
  logic [ADDRW-1:0]   key_addr;
  logic [ADDRW-1:0]   text_addr;
  logic               valid_out;
  logic               cpu_busy;
  logic               err_frame;
  logic               err_overflow;

  modport master (
    output spi_sclk, spi_cs_n, spi_mosi, ready_in_aes, ready_in_sha, err_clr,
    input  opcode, key_addr, text_addr, valid_out, cpu_busy, err_frame, err_overflow
  );

  modport slave (
    input  spi_sclk, spi_cs_n, spi_mosi, ready_in_aes, ready_in_sha, err_clr,
    output opcode, key_addr, text_addr, valid_out, cpu_busy, err_frame, err_overflow
  );

endinterface
`default_nettype wire

// File: rtl/sync_edge.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sync_edge: multi-flop synchroniser with registered edge detect    |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
      prev  <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      prev  <= chain[STAGES-1];
      rise  <= chain[STAGES-1] & ~prev;
      fall  <= ~chain[STAGES-1] & prev;
    end
  end

  assign sync_out = chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/req_deserializer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | req_deserializer: 3-wire serial instruction receiver, valid/ready |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module req_deserializer
  import ctrl_pkg::*;
#(
  parameter int ADDRW       = ctrl_pkg::ADDRW,
  parameter int OPCODEW     = ctrl_pkg::OPCODEW,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  req_deserializer_if.slave bus
);

  localparam int INSTRW = 2 * ADDRW + OPCODEW;
  localparam int CNTW   = $clog2(INSTRW + 2);
  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(INSTRW);
  localparam logic [CNTW-1:0] CNT_MAX  = CNTW'(INSTRW + 1);

  logic sclk_level, sclk_rise, sclk_fall;
  logic cs_level, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic unused_sclk;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk(clk), .rst(rst), .din(bus.spi_sclk),
    .sync_out(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_cs_sync (
    .clk(clk), .rst(rst), .din(bus.spi_cs_n),
    .sync_out(cs_level), .rise(cs_rise), .fall(cs_fall)
  );

  // mosi is sampled one cycle behind its synchroniser, so no edge stage is needed
  always_ff @(posedge clk) begin
    if (rst) mosi_sync <= '0;
    else     mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
  end

  assign unused_sclk = sclk_level ^ sclk_fall;

  state_t              state, state_nxt;
  logic [CNTW-1:0]     cnt, cnt_nxt;
  logic [INSTRW-1:0]   shreg, sh_nxt;
  logic                commit, frame_err;

  logic [OPCODEW-1:0]  opcode_q;
  logic [ADDRW-1:0]    key_q, text_q;
  logic                valid_q, err_frame_q, err_ovf_q;
  logic                xfer, load, drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WAIT_IDLE;
      cnt   <= '0;
      shreg <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      shreg <= sh_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sh_nxt    = shreg;
    commit    = 1'b0;
    frame_err = 1'b0;
    case (state)
      WAIT_IDLE: if (cs_level) state_nxt = IDLE;
      IDLE: begin
        if (cs_fall) begin
          state_nxt = SHIFT;
          cnt_nxt   = '0;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_nxt = IDLE;
          if (cnt == CNT_FULL) commit    = 1'b1;
          else                 frame_err = 1'b1;
        end else if (sclk_rise) begin
          sh_nxt = {shreg[INSTRW-2:0], mosi_sync[SYNC_STAGES-1]};
          if (cnt != CNT_MAX) cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = WAIT_IDLE;
    endcase
  end

  // Only the engine selected by the held opcode can accept it
  assign xfer = valid_q & (opcode_q[OP_SHA_BIT] ? bus.ready_in_sha : bus.ready_in_aes);
  assign load = commit & (~valid_q | xfer);
  assign drop = commit & valid_q & ~xfer;

  always_ff @(posedge clk) begin
    if (rst) begin
      opcode_q    <= '0;
      key_q       <= '0;
      text_q      <= '0;
      valid_q     <= 1'b0;
      err_frame_q <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      if (load) begin
        opcode_q <= shreg[INSTRW-1 -: OPCODEW];
        key_q    <= shreg[2*ADDRW-1 -: ADDRW];
        text_q   <= shreg[ADDRW-1:0];
        valid_q  <= 1'b1;
      end else if (xfer) begin
        valid_q  <= 1'b0;
      end
      err_frame_q <= (err_frame_q & ~bus.err_clr) | frame_err;
      err_ovf_q   <= (err_ovf_q & ~bus.err_clr) | drop;
    end
  end

  assign bus.opcode       = opcode_q;
  assign bus.key_addr     = key_q;
  assign bus.text_addr    = text_q;
  assign bus.valid_out    = valid_q;
  assign bus.cpu_busy     = valid_q;
  assign bus.err_frame    = err_frame_q;
  assign bus.err_overflow = err_ovf_q;

endmodule
`default_nettype wire

// File: doc/req_deserializer.md
Name: req_deserializer

Overview:
Front end of the control group. Receives 18-bit instructions from the crystal CPU over a 3-wire serial link (sclk / cs_n / mosi). Assembles each instruction into opcode, key_addr and text_addr, then presents it to the request queue with a valid/ready handshake. Routing uses opcode[0]: 0 = AES, 1 = SHA. Back-pressure comes from the queue's per-engine ready signals.

Parameters:
ADDRW, 8, width of key_addr and text_addr.
OPCODEW, 2, width of opcode.
SYNC_STAGES, 2, flop count of each input synchroniser (minimum 2).

Ports:
clk  in  1  system clock.
rst  in  1  synchronous, active-high reset.
spi_sclk  in  1  CPU serial clock, asynchronous to clk. Data is sampled on its rising edge.
spi_cs_n  in  1  frame select, active low, asynchronous.
spi_mosi  in  1  serial data, MSB first, asynchronous.
ready_in_aes  in  1  AES queue can accept an instruction.
ready_in_sha  in  1  SHA queue can accept an instruction.
opcode  out  OPCODEW  held instruction opcode.
key_addr  out  ADDRW  held key address.
text_addr  out  ADDRW  held text address.
valid_out  out  1  held instruction is valid.
cpu_busy  out  1  holding register occupied; equals valid_out.
err_frame  out  1  sticky: a frame ended with a bit count other than INSTRW.
err_overflow  out  1  sticky: a complete frame was dropped because the holding register was occupied.
err_clr  in  1  synchronous clear of both sticky error flags.

Behaviour:
- INSTRW = 2*ADDRW + OPCODEW = 18. Frame layout: {opcode, key_addr, text_addr}, MSB first (OOKKKKKKKKTTTTTTTT).
- Inputs sclk, cs_n and mosi pass through SYNC_STAGES flops. Edge detect on synced sclk (rise) and synced cs_n (fall and rise). spi_sclk must be at most clk/4.
- Reset: every output is 0. State goes to WAIT_IDLE, bit counter to 0, shift register to 0.
- State machine:
  - WAIT_IDLE -> IDLE when synced cs_n = 1. This also covers a reset released mid-frame, whose partial frame is ignored with no error.
  - IDLE -> SHIFT on a cs_n fall. The bit counter clears.
  - SHIFT, on each sclk rise: shift synced mosi into the LSB and increment the counter. The counter saturates at INSTRW+1.
  - SHIFT -> IDLE on a cs_n rise. If count == INSTRW the frame commits. Otherwise set err_frame and discard the frame.
- Commit happens in the cycle the cs_n rise is detected. The holding register and valid_out update at the next clk edge, so valid_out is high 1 cycle after detection.
- Transfer condition: valid_out && (opcode[0] ? ready_in_sha : ready_in_aes). The ready signal of the other engine is ignored. On a transfer, valid_out clears next cycle unless a commit occurs in the same cycle.
- While valid_out = 1, opcode, key_addr and text_addr are stable.
- Commit with valid_out = 1 and no transfer in the same cycle: the new frame is dropped, err_overflow is set, and the held instruction is unchanged.
- Commit in the same cycle as a transfer: the new instruction loads and valid_out stays 1 with no bubble.
- A new frame may be shifted in while one is held. Only the commit collides.
- err_clr clears the sticky flags. If err_clr and a new error occur in the same cycle, the flag stays set.
- Counter width is $clog2(INSTRW+2). The shift register is INSTRW bits wide; shifting past INSTRW bits is harmless because the frame is then flagged.

Decomposition:
- Shared package ctrl_pkg holds ADDRW, OPCODEW, INSTRW, OP_SHA_BIT = 0, and the state encoding (WAIT_IDLE, IDLE, SHIFT).
- One sub-module, sync_edge: a SYNC_STAGES synchroniser plus registered rise/fall detect. It is instantiated for sclk and cs_n; mosi uses the synchroniser only.

Test Plan:
- Send 18'b01_10100101_00111100 with ready_in_sha = 1 -> valid_out high for exactly 1 cycle with opcode = 01, key_addr = A5, text_addr = 3C; no errors.
- Send opcode 10 (key 0x11, text 0x22) with ready_in_aes = 0 and ready_in_sha = 1 -> valid_out and fields hold; set ready_in_aes = 1 -> valid_out drops the next cycle.
- 17-bit frame, then a 19-bit frame -> valid_out stays 0 and err_frame = 1; err_clr pulse -> err_frame = 0.
- Hold frame A with both readies 0, then send frame B -> err_overflow = 1 and fields still show A. Repeat with ready asserted exactly in B's commit cycle -> B is loaded, valid_out continuous, no error.
- Assert rst after 9 bits with cs_n still low, release it, finish the frame -> no valid_out and no err_frame. The next full frame is accepted normally.
